// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle sequencer: FSM states, opcodes,
// immediate formats and instruction classes.
package rv_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StDecode,
    StExecute,
    StMemory,
    StWriteback
  } state_e;

  typedef enum logic [3:0] {
    ClsIllegal,
    ClsLui,
    ClsAuipc,
    ClsJal,
    ClsJalr,
    ClsLoad,
    ClsOpImm,
    ClsStore,
    ClsBranch,
    ClsOp
  } instr_class_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] IMM_NONE = 3'd0;
  localparam logic [2:0] IMM_I    = 3'd1;
  localparam logic [2:0] IMM_S    = 3'd2;
  localparam logic [2:0] IMM_B    = 3'd3;
  localparam logic [2:0] IMM_U    = 3'd4;
  localparam logic [2:0] IMM_J    = 3'd5;

endpackage

// File: rtl/opcode_class_decode.sv
// Purely combinational opcode classifier: opcode -> {class, immediate format, legal}.
module opcode_class_decode
  import rv_ctrl_pkg::*;
(
  input  logic [6:0]   i_opcode,
  output instr_class_e o_class,
  output logic [2:0]   o_imm_sel,
  output logic         o_legal
);

  always_comb begin
    o_class   = ClsIllegal;
    o_imm_sel = IMM_NONE;
    o_legal   = 1'b1;
    case (i_opcode)
      OPC_LUI:    begin o_class = ClsLui;    o_imm_sel = IMM_U; end
      OPC_AUIPC:  begin o_class = ClsAuipc;  o_imm_sel = IMM_U; end
      OPC_JAL:    begin o_class = ClsJal;    o_imm_sel = IMM_J; end
      OPC_JALR:   begin o_class = ClsJalr;   o_imm_sel = IMM_I; end
      OPC_LOAD:   begin o_class = ClsLoad;   o_imm_sel = IMM_I; end
      OPC_OP_IMM: begin o_class = ClsOpImm;  o_imm_sel = IMM_I; end
      OPC_STORE:  begin o_class = ClsStore;  o_imm_sel = IMM_S; end
      OPC_BRANCH: begin o_class = ClsBranch; o_imm_sel = IMM_B; end
      OPC_OP:     begin o_class = ClsOp;     o_imm_sel = IMM_NONE; end
      default:    o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle DECODE/EXECUTE/MEMORY/WRITEBACK sequencer with instruction register,
// memory-wait timeout and retired-instruction counter.
module multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_instr_valid,
  input  logic [31:0] i_instruction,
  output logic        o_instr_ready,
  input  logic        i_mem_done,
  output logic [31:0] o_ir,
  output logic        o_imm_en,
  output logic [2:0]  o_imm_sel,
  output logic        o_alu_src_imm,
  output logic        o_mem_re,
  output logic        o_mem_we,
  output logic        o_reg_we,
  output logic        o_pc_we,
  output logic        o_illegal,
  output logic        o_mem_err,
  output logic [31:0] o_instret
);

  localparam int unsigned CntW = $clog2(MEM_TIMEOUT) + 1;

  state_e          r_state;
  logic [31:0]     r_ir;
  logic [31:0]     r_instret;
  logic [CntW-1:0] r_wait;

  instr_class_e w_class;
  logic [2:0]   w_imm_sel;
  logic         w_legal;
  logic         w_is_load;
  logic         w_is_store;
  logic         w_timeout;

  opcode_class_decode u_decode (
    .i_opcode  (r_ir[6:0]),
    .o_class   (w_class),
    .o_imm_sel (w_imm_sel),
    .o_legal   (w_legal)
  );

  assign w_is_load  = (w_class == ClsLoad);
  assign w_is_store = (w_class == ClsStore);
  assign w_timeout  = (r_wait == CntW'(MEM_TIMEOUT - 1));
  assign o_ir       = r_ir;
  assign o_instret  = r_instret;

  // Strobes are held low while reset is asserted so an abandoned access stays silent.
  always_comb begin
    o_instr_ready = 1'b0;
    o_imm_en      = 1'b0;
    o_imm_sel     = IMM_NONE;
    o_alu_src_imm = 1'b0;
    o_mem_re      = 1'b0;
    o_mem_we      = 1'b0;
    o_reg_we      = 1'b0;
    o_pc_we       = 1'b0;
    o_illegal     = 1'b0;
    o_mem_err     = 1'b0;
    if (!i_rst) begin
      unique case (r_state)
        StIdle: o_instr_ready = 1'b1;
        StDecode: begin
          if (w_legal) begin
            o_imm_en  = 1'b1;
            o_imm_sel = w_imm_sel;
          end else begin
            o_illegal = 1'b1;
          end
        end
        StExecute: begin
          o_alu_src_imm = !(w_class == ClsOp || w_class == ClsBranch);
          o_pc_we       = (w_class == ClsBranch);
        end
        StMemory: begin
          o_mem_re = w_is_load;
          o_mem_we = w_is_store;
          if (i_mem_done) o_pc_we = w_is_store;
          else o_mem_err = w_timeout;
        end
        StWriteback: begin
          o_reg_we = |r_ir[11:7];
          o_pc_we  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_ir      <= '0;
      r_wait    <= '0;
      r_instret <= '0;
    end else begin
      if (o_pc_we) r_instret <= r_instret + 32'd1;
      unique case (r_state)
        StIdle: begin
          if (i_instr_valid) begin
            r_ir    <= i_instruction;
            r_state <= StDecode;
          end
        end
        StDecode: r_state <= w_legal ? StExecute : StIdle;
        StExecute: begin
          r_wait <= '0;
          if (w_is_load || w_is_store) r_state <= StMemory;
          else if (w_class == ClsBranch) r_state <= StIdle;
          else r_state <= StWriteback;
        end
        StMemory: begin
          if (i_mem_done) r_state <= w_is_load ? StWriteback : StIdle;
          else if (w_timeout) r_state <= StIdle;
          else r_wait <= r_wait + CntW'(1);
        end
        StWriteback: r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl with MEM_TIMEOUT=4: one step per cycle,
// inputs driven after the falling edge, outputs checked 1ns later.
module tb_multicycle_ctrl;
  import rv_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic [31:0] instruction = '0;
  logic        mem_done = 1'b0;
  logic        instr_ready, imm_en, alu_src_imm, mem_re, mem_we, reg_we, pc_we;
  logic        illegal, mem_err;
  logic [2:0]  imm_sel;
  logic [31:0] ir, instret;

  int checks = 0;
  int errors = 0;

  multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_instr_valid (instr_valid),
    .i_instruction (instruction),
    .o_instr_ready (instr_ready),
    .i_mem_done    (mem_done),
    .o_ir          (ir),
    .o_imm_en      (imm_en),
    .o_imm_sel     (imm_sel),
    .o_alu_src_imm (alu_src_imm),
    .o_mem_re      (mem_re),
    .o_mem_we      (mem_we),
    .o_reg_we      (reg_we),
    .o_pc_we       (pc_we),
    .o_illegal     (illegal),
    .o_mem_err     (mem_err),
    .o_instret     (instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic [31:0] ins, input logic md, input logic r);
    @(negedge clk);
    instr_valid = v;
    instruction = ins;
    mem_done    = md;
    rst         = r;
    #1;
  endtask

  initial begin
    // Reset
    cyc(1'b1, 32'h00500093, 1'b0, 1'b1);
    chk("rst_ready_low", instr_ready, 0);
    chk("rst_pc_we_low", pc_we, 0);
    cyc(1'b0, 0, 1'b0, 1'b1);
    cyc(1'b0, 0, 1'b0, 1'b0);
    chk("idle_ready", instr_ready, 1);
    chk("idle_ir", ir, 0);
    chk("idle_instret", instret, 0);

    // ADDI x1,x0,5
    cyc(1'b1, 32'h00500093, 1'b0, 1'b0);
    chk("addi_c0_ready", instr_ready, 1);
    cyc(1'b0, 0, 1'b0, 1'b0);
    chk("addi_c1_imm_en", imm_en, 1);
    chk("addi_c1_imm_sel", imm_sel, 1);
    chk("addi_c1_ready", instr_ready, 0);
    chk("addi_c1_ir", ir, 32'h00500093);
    cyc(1'b0, 0, 1'b0, 1'b0);
    chk("addi_c2_alu_imm", alu_src_imm, 1);
    chk("addi_c2_pc_we", pc_we, 0);
    cyc(1'b0, 0, 1'b0, 1'b0);
    chk("addi_c3_reg_we", reg_we, 1);
    chk("addi_c3_pc_we", pc_we, 1);
    cyc(1'b0, 0, 1'b0, 1'b0);
    chk("addi_c4_ready", instr_ready, 1);
    chk("addi_c4_instret", instret, 1);

    // BEQ
    cyc(1'b1, 32'h00000463, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b0);
    chk("beq_c1_imm_sel", imm_sel, 3);
    cyc(1'b0, 0, 1'b0, 1'b0);
    chk("beq_c2_pc_we", pc_we, 1);
    chk("beq_c2_reg_we", reg_we, 0);
    chk("beq_c2_alu_imm", alu_src_imm, 0);
    cyc(1'b0, 0, 1'b0, 1'b0);
    chk("beq_c3_ready", instr_ready, 1);
    chk("beq_c3_instret", instret, 2);

    // LW x2,0(x0): three waits, then done exactly at the timeout limit (done wins)
    cyc(1'b1, 32'h00002103, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b0);
    chk("lw_c1_imm_sel", imm_sel, 1);
    cyc(1'b0, 0, 1'b0, 1'b0);
    chk("lw_c2_alu_imm", alu_src_imm, 1);
    chk("lw_c2_mem_re", mem_re, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 0, 1'b0, 1'b0);
      chk("lw_wait_mem_re", mem_re, 1);
      chk("lw_wait_mem_err", mem_err, 0);
    end
    cyc(1'b0, 0, 1'b1, 1'b0);
    chk("lw_done_mem_re", mem_re, 1);
    chk("lw_done_mem_err", mem_err, 0);
    chk("lw_done_pc_we", pc_we, 0);
    cyc(1'b0, 0, 1'b0, 1'b0);
    chk("lw_wb_reg_we", reg_we, 1);
    chk("lw_wb_pc_we", pc_we, 1);
    cyc(1'b0, 0, 1'b0, 1'b0);
    chk("lw_ready", instr_ready, 1);
    chk("lw_instret", instret, 3);

    // SW x2,0(x0) never completed: timeout on the 4th MEMORY cycle
    cyc(1'b1, 32'h00202023, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b0);
    chk("sw_c1_imm_sel", imm_sel, 2);
    cyc(1'b0, 0, 1'b0, 1'b0);
    chk("sw_c2_alu_imm", alu_src_imm, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 0, 1'b0, 1'b0);
      chk("sw_wait_mem_we", mem_we, 1);
      chk("sw_wait_mem_err", mem_err, 0);
    end
    cyc(1'b0, 0, 1'b0, 1'b0);
    chk("sw_to_mem_we", mem_we, 1);
    chk("sw_to_mem_err", mem_err, 1);
    chk("sw_to_pc_we", pc_we, 0);
    cyc(1'b0, 0, 1'b0, 1'b0);
    chk("sw_to_ready", instr_ready, 1);
    chk("sw_to_instret", instret, 3);

    // Illegal opcode 0x7F
    cyc(1'b1, 32'h0000007F, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b0);
    chk("ill_c1_illegal", illegal, 1);
    chk("ill_c1_imm_en", imm_en, 0);
    cyc(1'b0, 0, 1'b0, 1'b0);
    chk("ill_c2_ready", instr_ready, 1);
    chk("ill_c2_illegal", illegal, 0);
    chk("ill_c2_instret", instret, 3);

    // ADDI x0,x0,0: retires without a register write
    cyc(1'b1, 32'h00000013, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b0);
    chk("nop_wb_reg_we", reg_we, 0);
    chk("nop_wb_pc_we", pc_we, 1);
    cyc(1'b0, 0, 1'b0, 1'b0);
    chk("nop_instret", instret, 4);

    // LUI x1,1
    cyc(1'b1, 32'h000010B7, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b0);
    chk("lui_c1_imm_sel", imm_sel, 4);
    cyc(1'b0, 0, 1'b0, 1'b0);
    chk("lui_c2_alu_imm", alu_src_imm, 1);
    cyc(1'b0, 0, 1'b0, 1'b0);
    chk("lui_c3_reg_we", reg_we, 1);
    cyc(1'b0, 0, 1'b0, 1'b0);
    chk("lui_instret", instret, 5);

    // Reset during the 2nd MEMORY cycle of a load
    cyc(1'b1, 32'h00002103, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b0);
    chk("rstmem_m1_mem_re", mem_re, 1);
    cyc(1'b0, 0, 1'b0, 1'b1);
    chk("rstmem_mem_re", mem_re, 0);
    chk("rstmem_mem_err", mem_err, 0);
    chk("rstmem_ready", instr_ready, 0);
    cyc(1'b0, 0, 1'b0, 1'b0);
    chk("rstmem_idle_ready", instr_ready, 1);
    chk("rstmem_ir", ir, 0);
    chk("rstmem_instret", instret, 0);
    chk("rstmem_reg_we", reg_we, 0);
    chk("rstmem_pc_we", pc_we, 0);

    // instret wrap from a forced all-ones value
    @(negedge clk);
    force dut.r_instret = 32'hFFFFFFFF;
    #1;
    release dut.r_instret;
    #1;
    chk("wrap_preload", instret, 32'hFFFFFFFF);
    cyc(1'b1, 32'h00500093, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b0);
    chk("wrap_pc_we", pc_we, 1);
    cyc(1'b0, 0, 1'b0, 1'b0);
    chk("wrap_instret", instret, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
